// File: rtl/exp_stream_ctrl_if.sv
// Operand/result stream bundle between the exp sequencer and its neighbours.
// slave = controller side, master = producer/consumer side.
`timescale 1ns/1ps
interface exp_stream_ctrl_if #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 10
) ();
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_err);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_err);
endinterface

// File: rtl/exp_stream_ctrl.sv
// Sequencer for the 8-iteration shift-add exp core: one init per operand,
// operand held for the whole op, stale done masked, result on a registered stream.
`timescale 1ns/1ps
module exp_stream_ctrl #(
  parameter int IN_W        = 9,
  parameter int OUT_W       = 10,
  parameter int GUARD_CYC   = 3,
  parameter int TIMEOUT_CYC = 20,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  exp_stream_ctrl_if.slave  s,
  output logic              exp_init,
  output logic [IN_W-1:0]   exp_value_in,
  input  logic [OUT_W-1:0]  exp_value_out,
  input  logic              exp_done,
  output logic              busy,
  output logic [15:0]       op_count
);
  typedef enum logic [1:0] {IDLE, INIT, RUN, HOLD} state_t;

  localparam logic [CNT_W-1:0] GUARD = CNT_W'(GUARD_CYC);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_CYC);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] cap_data;
  logic             cap_err;
  logic             accept, qual_done, tmo_hit, load;

  assign s.in_ready = (state == IDLE) && !rst;
  assign accept     = s.in_valid && s.in_ready;
  assign qual_done  = (state == RUN) && (cnt >= GUARD) && exp_done;
  // a genuine done on the timeout cycle still wins over the timeout
  assign tmo_hit    = (state == RUN) && (cnt == TMO) && !qual_done;
  assign load       = (state == HOLD) && (!s.out_valid || s.out_ready);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = INIT;
      INIT:    state_nx = RUN;
      RUN:     if (qual_done || tmo_hit) state_nx = HOLD;
      HOLD:    if (load) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      exp_init     <= 1'b0;
      exp_value_in <= '0;
      cnt          <= '0;
      cap_data     <= '0;
      cap_err      <= 1'b0;
      s.out_valid  <= 1'b0;
      s.out_data   <= '0;
      s.out_err    <= 1'b0;
      op_count     <= '0;
    end else begin
      state    <= state_nx;
      // registered so the pulse lines up exactly with the INIT cycle
      exp_init <= accept;
      if (accept) exp_value_in <= s.in_data;
      if (state == INIT)                 cnt <= '0;
      else if (state == RUN && cnt != TMO) cnt <= cnt + 1'b1;
      // the core overwrites value_out a few cycles after done, so grab it now
      if (qual_done || tmo_hit) begin
        cap_data <= exp_value_out;
        cap_err  <= tmo_hit;
      end
      if (load) begin
        s.out_valid <= 1'b1;
        s.out_data  <= cap_data;
        s.out_err   <= cap_err;
        op_count    <= op_count + 16'd1;
      end else if (s.out_valid && s.out_ready) begin
        s.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exp_stream_ctrl.sv
// Bench for exp_stream_ctrl: behavioural exp core, scoreboard of expected results,
// directed scenarios followed by randomized operand/latency/back-pressure traffic.
`timescale 1ns/1ps
module tb_exp_stream_ctrl;
  localparam int IN_W = 9, OUT_W = 10, GUARD = 3, TMO = 20, NEVER = 5000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exp_stream_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) sif ();
  logic             exp_init, exp_done, busy;
  logic [IN_W-1:0]  exp_value_in;
  logic [OUT_W-1:0] exp_value_out;
  logic [15:0]      op_count;

  exp_stream_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .GUARD_CYC(GUARD),
                    .TIMEOUT_CYC(TMO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .s(sif.slave), .exp_init(exp_init),
    .exp_value_in(exp_value_in), .exp_value_out(exp_value_out),
    .exp_done(exp_done), .busy(busy), .op_count(op_count));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Core model: stale done for 2 cycles after init, real done L cycles after
  // init (sticky), result valid for 9 cycles then overwritten.
  int since = 0, lat_cfg = 10, lat_cur = NEVER;
  always @(posedge clk) begin
    if (rst) since <= 0;
    else if (exp_init) begin since <= 1; lat_cur <= lat_cfg; end
    else if (since > 0 && since < 10000) since <= since + 1;
  end

  function automatic logic [OUT_W-1:0] res_of(input logic [IN_W-1:0] x);
    int v;
    v = 128 + int'($signed(x));
    return v[OUT_W-1:0];
  endfunction

  always @* begin
    exp_done = (since == 1) || (since == 2) || (since > 0 && since >= lat_cur);
    if (since > 0 && since >= lat_cur + 9)  exp_value_out = 10'h1A5;
    else if (since > 0 && since >= lat_cur) exp_value_out = res_of(exp_value_in);
    else                                    exp_value_out = 10'h2AA;
  end

  // Reference rules: done is honoured from GUARD+1 cycles after init; past
  // TMO+1 cycles the op times out and returns whatever the core shows.
  typedef struct { logic [OUT_W-1:0] d; logic e; } exp_t;
  exp_t q[$];

  function automatic exp_t model(input logic [IN_W-1:0] x, input int L);
    exp_t r;
    if (L > TMO + 1) begin r.d = 10'h2AA; r.e = 1'b1; end
    else begin r.d = res_of(x); r.e = 1'b0; end
    return r;
  endfunction

  function automatic int lat_of(input int L);
    int c;
    c = (L > TMO + 1) ? TMO + 1 : (L < GUARD + 1) ? GUARD + 1 : L;
    return c + 2;
  endfunction

  logic [IN_W-1:0] cur_x;
  bit track = 0, prev_init = 0;
  int init_cnt = 0, acc_cnt = 0, acc_rst = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete(); track = 0; prev_init = 0; acc_rst = 0;
    end else begin
      if (track) chk("value_in_held", exp_value_in, cur_x);
      if (exp_init) begin init_cnt++; chk("init_width", prev_init, 0); end
      prev_init = exp_init;
      if (sif.in_valid && sif.in_ready) begin
        q.push_back(model(sif.in_data, lat_cfg));
        cur_x = sif.in_data; track = 1; acc_cnt++; acc_rst++;
      end
      if (sif.out_valid) begin
        if (q.size() == 0) chk("out_when_empty", sif.out_valid, 0);
        else begin
          chk("out_data", sif.out_data, q[0].d);
          chk("out_err", sif.out_err, q[0].e);
          if (sif.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  bit rnd_rdy = 0;
  always @(posedge clk) if (rnd_rdy) begin #1; sif.out_ready = 1'($urandom_range(0, 1)); end

  task automatic set_rdy(input logic v);
    @(posedge clk); #1; sif.out_ready = v;
  endtask

  // returns one edge after INIT so the core has latched this op's latency
  task automatic send(input logic [IN_W-1:0] x, input int L);
    int k = 0;
    @(posedge clk); #1;
    sif.in_valid = 1'b1; sif.in_data = x; lat_cfg = L;
    do begin @(negedge clk); k++; end while (!sif.in_ready && k < 300);
    chk("accept_wait", sif.in_ready, 1);
    @(posedge clk); #1;
    sif.in_valid = 1'b0; sif.in_data = IN_W'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic run_one(input logic [IN_W-1:0] x, input int L);
    int k = 1;
    send(x, L);
    forever begin
      @(negedge clk);
      if (sif.out_valid || k > 60) break;
      chk("in_ready_busy", sif.in_ready, 0);
      k++;
    end
    chk("latency", k, lat_of(L));
  endtask

  task automatic wait_idle(input int n);
    int k = 0;
    while ((q.size() != 0 || busy) && k < n) begin @(negedge clk); k++; end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lc;
    rst = 1'b1; sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", sif.in_ready, 0);
    chk("rst_out_valid", sif.out_valid, 0);
    chk("rst_out_data", sif.out_data, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_init", exp_init, 0);
    chk("rst_value_in", exp_value_in, 0);
    @(posedge clk); #1; rst = 1'b0; sif.out_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready", sif.in_ready, 1);
    chk("idle_busy", busy, 0);

    // single op, x=0 -> 1.0
    run_one(9'h000, 10);
    chk("first_data", sif.out_data, 10'h080);
    chk("first_err", sif.out_err, 0);
    chk("first_count", op_count, 1);
    chk("first_inits", init_cnt, 1);

    // back-to-back
    run_one(9'h040, 10);
    chk("b2b_a", sif.out_data, 10'h0C0);
    run_one(9'h1C0, 10);
    chk("b2b_b", sif.out_data, 10'h040);

    // guard and timeout boundaries, then recovery
    run_one(9'h011, 3);
    run_one(9'h012, 4);
    run_one(9'h013, TMO + 1);
    chk("done_at_timeout_err", sif.out_err, 0);
    run_one(9'h014, TMO + 2);
    chk("timeout_edge_err", sif.out_err, 1);
    run_one(9'h0F0, NEVER);
    chk("timeout_err", sif.out_err, 1);
    run_one(9'h0F1, 10);
    chk("recover_err", sif.out_err, 0);
    wait_idle(50);
    chk("count_mid", op_count, 16'(acc_rst));

    // back-pressure: second op parks in HOLD behind result 1
    set_rdy(1'b0);
    run_one(9'h021, 10);
    send(9'h155, 10);
    repeat (30) @(negedge clk);
    chk("park_busy", busy, 1);
    chk("park_data", sif.out_data, res_of(9'h021));
    chk("park_count", op_count, 16'(acc_rst - 1));
    @(posedge clk); #1; sif.in_valid = 1'b1; sif.in_data = 9'h0AA;
    repeat (3) begin @(negedge clk); chk("park_ready", sif.in_ready, 0); end
    @(posedge clk); #1; sif.in_valid = 1'b0;
    @(negedge clk);
    set_rdy(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("reload_valid", sif.out_valid, 1);
    chk("reload_data", sif.out_data, res_of(9'h155));
    chk("reload_count", op_count, 16'(acc_rst));
    @(negedge clk);
    chk("reload_drained", sif.out_valid, 0);

    // reset mid-RUN with a pending output
    set_rdy(1'b0);
    run_one(9'h033, 10);
    send(9'h034, 10);
    repeat (4) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rst_run_ready", sif.in_ready, 0);
    @(negedge clk);
    chk("rst_run_valid", sif.out_valid, 0);
    chk("rst_run_busy", busy, 0);
    chk("rst_run_count", op_count, 0);
    chk("rst_run_init", exp_init, 0);
    chk("rst_run_vin", exp_value_in, 0);
    @(posedge clk); #1; rst = 1'b0; sif.out_ready = 1'b1;
    lc = init_cnt;
    @(negedge clk);
    chk("post_rst_ready", sif.in_ready, 1);
    repeat (30) @(negedge clk);
    chk("abandon_valid", sif.out_valid, 0);
    chk("abandon_inits", init_cnt, lc);

    // random operands and latencies, always-ready sink
    repeat (40) begin
      lc = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(1, 26);
      run_one(IN_W'($urandom), lc);
    end
    // random operands under random back-pressure
    rnd_rdy = 1;
    repeat (30) send(IN_W'($urandom), $urandom_range(1, 24));
    rnd_rdy = 0;
    set_rdy(1'b1);
    wait_idle(500);
    @(negedge clk);
    chk("rand_count", op_count, 16'(acc_rst));
    chk("init_count", init_cnt, acc_cnt);

    // op_count wrap
    force dut.op_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.op_count;
    @(negedge clk);
    chk("preset_count", op_count, 16'hFFFF);
    run_one(IN_W'($urandom), 10);
    chk("wrap_count", op_count, 16'h0000);
    wait_idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exp_stream_ctrl.md
Name: exp_stream_ctrl

Overview:
- Upstream sequencer for the 8-iteration shift-add exponential core (`init` / `value_in` / `value_out` / `done` interface).
- Accepts a stream of signed fixed-point operands on a valid/ready handshake and issues exactly one `init` pulse per operand.
- Holds the core's operand stable for the whole computation, qualifies the core's sticky/stale `done`, and captures `value_out` on the first genuine `done`.
- Presents each result on a registered valid/ready output with a per-result timeout error flag. Feeds the spiking-neuron decay datapath downstream.

Parameters:
- IN_W, 9, operand width (signed, bit IN_W-1 is sign, 1.0 = 128).
- OUT_W, 10, result width (1.0 = 128).
- GUARD_CYC, 3, cycles after the `init` pulse during which `exp_done` is ignored (stale done from the previous operation).
- TIMEOUT_CYC, 20, cycles after the `init` pulse at which the operation is abandoned; must exceed GUARD_CYC.
- CNT_W, 5, width of the internal cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand available
- in_ready  out  1  controller can accept an operand
- in_data  in  IN_W  signed operand x
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  OUT_W  exp(x) as returned by the core
- out_err  out  1  result produced by timeout, not by core done
- exp_init  out  1  one-cycle start pulse to the core's `init`
- exp_value_in  out  IN_W  operand to the core's `value_in`, held stable
- exp_value_out  in  OUT_W  core result
- exp_done  in  1  core done flag
- busy  out  1  high in any state other than IDLE
- op_count  out  16  completed results handed off; wraps at 0xFFFF -> 0

Behaviour:
- Synchronous reset, active-high:
  - state = IDLE; out_valid, out_data, out_err, exp_init, exp_value_in, op_count, internal counter and capture registers all 0.
  - in_ready = 0 while rst is high.
- in_ready = (state == IDLE) && !rst. This is combinational from the state register.
- States: IDLE, INIT, RUN, HOLD.
- IDLE:
  - On in_valid && in_ready, latch in_data into exp_value_in and go to INIT. No other state accepts input.
- INIT (exactly one cycle):
  - exp_init = 1; counter cleared to 0; go to RUN. exp_init is 0 in every other state.
- RUN:
  - Counter increments every cycle, saturating at TIMEOUT_CYC.
  - exp_done is ignored while counter < GUARD_CYC.
  - Counter >= GUARD_CYC and exp_done = 1: capture exp_value_out into the capture register, cap_err = 0, go to HOLD.
  - Counter reaches TIMEOUT_CYC with no qualified done: capture exp_value_out anyway, cap_err = 1, go to HOLD.
  - Capture must happen on the first qualified done cycle, because the core free-runs after done and overwrites value_out about 9 cycles later.
- HOLD:
  - If !out_valid or (out_valid && out_ready): out_data <= capture, out_err <= cap_err, out_valid <= 1, op_count++, go to IDLE.
  - Otherwise stay in HOLD; the capture register is unchanged.
- Output register:
  - out_valid clears on out_valid && out_ready unless it is reloaded the same cycle. A simultaneous drain and load leaves out_valid = 1 with the new data.
  - out_data and out_err are stable while out_valid && !out_ready.
- exp_value_in is unchanged from the IDLE accept until the next accept, including through HOLD, because the core samples the operand sign every iteration.
- Nominal latency, accept edge to out_valid: 1 (INIT) + done arrival (about 10 cycles after the init pulse for this core) + 1 (HOLD load) cycles.
- Throughput: one operation in flight at a time; the next accept is the cycle after HOLD exits.
- Reset mid-operation: abandons everything, including a pending output; the core sees no further exp_init.
- in_valid while busy: ignored, not queued. in_data may change freely while in_ready = 0.

Test Plan:
- Behavioural core model (done after 10 cycles, value_out = 0x080, stale done = 1 for the first 2 cycles after init). Drive in_data = 0 -> exactly one exp_init pulse; out_valid with out_data = 0x080, out_err = 0; op_count = 1; stale done not captured.
- Back-to-back operands 0x040, 0x1C0 with out_ready = 1 -> two results in order; each exp_init one cycle wide; exp_value_in stable throughout each RUN; in_ready = 0 from accept until HOLD exits.
- out_ready = 0 for 30 cycles after the first result, second operand accepted -> second op parks in HOLD; out_data stays on result 1. Raise out_ready -> same-cycle drain and reload, out_valid stays 1, then result 2 delivered.
- Core model never raises done -> after TIMEOUT_CYC = 20 cycles, out_valid = 1 with out_err = 1; next operand processes normally with out_err = 0.
- Assert rst during RUN -> next edge all outputs 0, state IDLE, in_ready = 1 the cycle after rst falls; no capture of the abandoned op.
- op_count preset path: run 65536 operations (or force the counter to 0xFFFF) -> wraps to 0x0000 on the next handoff.
